// File: rtl/spi_queue_regs.sv
// SPI register stage: TX/RX word FIFOs, shadowed core configuration and a sequencer
// that launches back-to-back transfers; config reaches the core only between words.
module spi_queue_regs #(
    parameter int DATA_W   = 32,
    parameter int TX_DEPTH = 4,
    parameter int RX_DEPTH = 4,
    parameter bit RX_DROP  = 1'b0
) (
    input  logic                          GCLK,
    input  logic                          RST,
    input  logic                          enable_i,
    input  logic                          cfg_we_i,
    input  logic [1:0]                    spi_mode_i,
    input  logic [1:0]                    sck_speed_i,
    input  logic [1:0]                    word_len_i,
    input  logic [7:0]                    ifg_i,
    input  logic [7:0]                    cs_sck_i,
    input  logic [7:0]                    sck_cs_i,
    input  logic                          tx_valid_i,
    input  logic [DATA_W-1:0]             tx_data_i,
    output logic                          tx_ready_o,
    output logic                          rx_valid_o,
    output logic [DATA_W-1:0]             rx_data_o,
    input  logic                          rx_ready_i,
    output logic [$clog2(TX_DEPTH+1)-1:0] tx_level_o,
    output logic [$clog2(RX_DEPTH+1)-1:0] rx_level_o,
    output logic                          rx_ovf_o,
    input  logic                          ovf_clr_i,
    output logic                          busy_o,
    output logic                          core_start_o,
    input  logic                          core_busy_i,
    output logic [DATA_W-1:0]             core_mosi_o,
    input  logic [DATA_W-1:0]             core_miso_i,
    output logic [1:0]                    core_spi_mode_o,
    output logic [1:0]                    core_sck_speed_o,
    output logic [1:0]                    core_word_len_o,
    output logic [7:0]                    core_ifg_o,
    output logic [7:0]                    core_cs_sck_o,
    output logic [7:0]                    core_sck_cs_o
);
    localparam int TX_PW = $clog2(TX_DEPTH);
    localparam int RX_PW = $clog2(RX_DEPTH);
    localparam int TX_CW = $clog2(TX_DEPTH + 1);
    localparam int RX_CW = $clog2(RX_DEPTH + 1);
    localparam logic [TX_CW-1:0] TX_FULL_LVL = TX_CW'(TX_DEPTH);
    localparam logic [RX_CW-1:0] RX_FULL_LVL = RX_CW'(RX_DEPTH);
    localparam logic [TX_CW-1:0] TX_CNT_ONE  = TX_CW'(1);
    localparam logic [RX_CW-1:0] RX_CNT_ONE  = RX_CW'(1);
    localparam logic [TX_PW-1:0] TX_PTR_ONE  = TX_PW'(1);
    localparam logic [RX_PW-1:0] RX_PTR_ONE  = RX_PW'(1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_APPLY     = 3'd1,
        ST_LAUNCH    = 3'd2,
        ST_WAIT_BUSY = 3'd3,
        ST_RUN       = 3'd4,
        ST_CAPTURE   = 3'd5
    } state_t;

    typedef struct packed {
        logic [1:0] spi_mode;
        logic [1:0] sck_speed;
        logic [1:0] word_len;
        logic [7:0] ifg;
        logic [7:0] cs_sck;
        logic [7:0] sck_cs;
    } cfg_t;

    state_t            state_q, state_d;
    cfg_t              shadow_q, shadow_d, active_q, active_d;
    logic              pending_q, pending_d;
    logic [DATA_W-1:0] tx_mem_q [TX_DEPTH];
    logic [DATA_W-1:0] tx_mem_d [TX_DEPTH];
    logic [DATA_W-1:0] rx_mem_q [RX_DEPTH];
    logic [DATA_W-1:0] rx_mem_d [RX_DEPTH];
    logic [TX_PW-1:0]  tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
    logic [RX_PW-1:0]  rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
    logic [TX_CW-1:0]  tx_cnt_q, tx_cnt_d;
    logic [RX_CW-1:0]  rx_cnt_q, rx_cnt_d;
    logic [DATA_W-1:0] mosi_q, mosi_d;
    logic              start_q, start_d, tx_ready_q, tx_ready_d, rx_valid_q, rx_valid_d;
    logic              busy_q, busy_d, ovf_q, ovf_d;
    logic              tx_full_s, tx_empty_s, rx_full_s, rx_empty_s;
    logic              tx_push_s, tx_pop_s, rx_push_s, rx_pop_s, rx_drop_s, launch_ok_s;

    assign tx_full_s   = (tx_cnt_q == TX_FULL_LVL);
    assign tx_empty_s  = (tx_cnt_q == '0);
    assign rx_full_s   = (rx_cnt_q == RX_FULL_LVL);
    assign rx_empty_s  = (rx_cnt_q == '0);
    // A full FIFO refuses writes even when it is popped in the same cycle.
    assign tx_push_s   = tx_valid_i && !tx_full_s;
    assign tx_pop_s    = (state_q == ST_LAUNCH) && !tx_empty_s;
    assign rx_push_s   = (state_q == ST_CAPTURE) && !rx_full_s;
    assign rx_pop_s    = rx_ready_i && !rx_empty_s;
    assign rx_drop_s   = (state_q == ST_CAPTURE) && rx_full_s && RX_DROP;
    assign launch_ok_s = enable_i && !tx_empty_s && (RX_DROP || !rx_full_s);

    // Transfer sequencer next-state logic; a pending config always goes first.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (pending_q) begin
                    state_d = ST_APPLY;
                end else if (launch_ok_s) begin
                    state_d = ST_LAUNCH;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_APPLY:     state_d = ST_IDLE;
            ST_LAUNCH:    state_d = ST_WAIT_BUSY;
            ST_WAIT_BUSY: state_d = core_busy_i ? ST_RUN : ST_WAIT_BUSY;
            ST_RUN:       state_d = core_busy_i ? ST_RUN : ST_CAPTURE;
            ST_CAPTURE:   state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    // FIFO, config and registered-output next values.
    always_comb begin
        tx_mem_d = tx_mem_q;
        rx_mem_d = rx_mem_q;
        if (tx_push_s) begin
            tx_mem_d[tx_wr_q] = tx_data_i;
            tx_wr_d           = tx_wr_q + TX_PTR_ONE;
        end else begin
            tx_wr_d = tx_wr_q;
        end
        tx_rd_d = tx_pop_s ? (tx_rd_q + TX_PTR_ONE) : tx_rd_q;
        if (rx_push_s) begin
            rx_mem_d[rx_wr_q] = core_miso_i;
            rx_wr_d           = rx_wr_q + RX_PTR_ONE;
        end else begin
            rx_wr_d = rx_wr_q;
        end
        rx_rd_d = rx_pop_s ? (rx_rd_q + RX_PTR_ONE) : rx_rd_q;

        case ({tx_push_s, tx_pop_s})
            2'b10:   tx_cnt_d = tx_cnt_q + TX_CNT_ONE;
            2'b01:   tx_cnt_d = tx_cnt_q - TX_CNT_ONE;
            default: tx_cnt_d = tx_cnt_q;
        endcase
        case ({rx_push_s, rx_pop_s})
            2'b10:   rx_cnt_d = rx_cnt_q + RX_CNT_ONE;
            2'b01:   rx_cnt_d = rx_cnt_q - RX_CNT_ONE;
            default: rx_cnt_d = rx_cnt_q;
        endcase

        shadow_d  = cfg_we_i ? cfg_t'{spi_mode_i, sck_speed_i, word_len_i, ifg_i, cs_sck_i, sck_cs_i}
                             : shadow_q;
        active_d  = (state_q == ST_APPLY) ? shadow_q : active_q;
        if (cfg_we_i) begin
            pending_d = 1'b1;
        end else if (state_q == ST_APPLY) begin
            pending_d = 1'b0;
        end else begin
            pending_d = pending_q;
        end
        if (rx_drop_s) begin
            ovf_d = 1'b1;
        end else if (ovf_clr_i) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end

        // The word is presented on entry to LAUNCH so it is valid alongside the start pulse.
        mosi_d     = (state_d == ST_LAUNCH) ? tx_mem_q[tx_rd_q] : mosi_q;
        start_d    = (state_d == ST_LAUNCH);
        tx_ready_d = (tx_cnt_d != TX_FULL_LVL);
        rx_valid_d = (rx_cnt_d != '0);
        busy_d     = (state_d != ST_IDLE) || (tx_cnt_d != '0);
    end

    // All state; reset abandons any word in flight and flushes both FIFOs.
    always_ff @(posedge GCLK) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            shadow_q   <= '0;
            active_q   <= '0;
            pending_q  <= 1'b0;
            tx_mem_q   <= '{default: '0};
            rx_mem_q   <= '{default: '0};
            tx_wr_q    <= '0;
            tx_rd_q    <= '0;
            rx_wr_q    <= '0;
            rx_rd_q    <= '0;
            tx_cnt_q   <= '0;
            rx_cnt_q   <= '0;
            mosi_q     <= '0;
            start_q    <= 1'b0;
            tx_ready_q <= 1'b1;
            rx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            shadow_q   <= shadow_d;
            active_q   <= active_d;
            pending_q  <= pending_d;
            tx_mem_q   <= tx_mem_d;
            rx_mem_q   <= rx_mem_d;
            tx_wr_q    <= tx_wr_d;
            tx_rd_q    <= tx_rd_d;
            rx_wr_q    <= rx_wr_d;
            rx_rd_q    <= rx_rd_d;
            tx_cnt_q   <= tx_cnt_d;
            rx_cnt_q   <= rx_cnt_d;
            mosi_q     <= mosi_d;
            start_q    <= start_d;
            tx_ready_q <= tx_ready_d;
            rx_valid_q <= rx_valid_d;
            busy_q     <= busy_d;
            ovf_q      <= ovf_d;
        end
    end

    assign tx_ready_o       = tx_ready_q;
    assign rx_valid_o       = rx_valid_q;
    assign rx_data_o        = rx_mem_q[rx_rd_q];
    assign tx_level_o       = tx_cnt_q;
    assign rx_level_o       = rx_cnt_q;
    assign rx_ovf_o         = ovf_q;
    assign busy_o           = busy_q;
    assign core_start_o     = start_q;
    assign core_mosi_o      = mosi_q;
    assign core_spi_mode_o  = active_q.spi_mode;
    assign core_sck_speed_o = active_q.sck_speed;
    assign core_word_len_o  = active_q.word_len;
    assign core_ifg_o       = active_q.ifg;
    assign core_cs_sck_o    = active_q.cs_sck;
    assign core_sck_cs_o    = active_q.sck_cs;
endmodule

// File: tb/tb_spi_queue_regs.sv
// Bench for spi_queue_regs: one instance per RX_DROP setting, each driven by a simple
// core stand-in that stays busy a few cycles and returns the inverted MOSI word.
module tb_spi_queue_regs;
    typedef struct {
        logic [31:0] tx;
        logic [31:0] rx;
    } vec_t;

    logic        GCLK = 1'b0;
    logic        RST = 1'b1;
    logic        enable = 1'b0, cfg_we = 1'b0, tx_valid = 1'b0, rx_ready = 1'b0, ovf_clr = 1'b0;
    logic [1:0]  spi_mode = 2'd0, sck_speed = 2'd0, word_len = 2'd0;
    logic [7:0]  ifg = 8'd0, cs_sck = 8'd0, sck_cs = 8'd0;
    logic [31:0] tx_data = 32'd0;

    logic        tx_ready0, rx_valid0, ovf0, busy_o0, start0;
    logic [31:0] rx_data0, mosi0;
    logic [2:0]  tx_level0, rx_level0;
    logic [1:0]  mode0, speed0, wlen0;
    logic [7:0]  ifg0, cssck0, sckcs0;
    logic        tx_ready1, rx_valid1, ovf1, busy_o1, start1;
    logic [31:0] rx_data1, mosi1;
    logic [2:0]  tx_level1, rx_level1;
    logic [1:0]  mode1, speed1, wlen1;
    logic [7:0]  ifg1, cssck1, sckcs1;

    logic        cbusy0 = 1'b0, cbusy1 = 1'b0, core_hold = 1'b0;
    logic [31:0] miso0 = 32'd0, miso1 = 32'd0, cword0 = 32'd0, cword1 = 32'd0;
    int          ccnt0 = 0, ccnt1 = 0, core_len = 3, cyc = 0, fall_cyc0 = 0;
    int          starts0[$];
    logic [31:0] exp_q[$];
    int          n_checks = 0, n_errors = 0;
    vec_t        vecs[6];

    spi_queue_regs #(.DATA_W(32), .TX_DEPTH(4), .RX_DEPTH(4), .RX_DROP(1'b0)) d0 (
        .GCLK(GCLK), .RST(RST), .enable_i(enable), .cfg_we_i(cfg_we), .spi_mode_i(spi_mode),
        .sck_speed_i(sck_speed), .word_len_i(word_len), .ifg_i(ifg), .cs_sck_i(cs_sck),
        .sck_cs_i(sck_cs), .tx_valid_i(tx_valid), .tx_data_i(tx_data), .tx_ready_o(tx_ready0),
        .rx_valid_o(rx_valid0), .rx_data_o(rx_data0), .rx_ready_i(rx_ready),
        .tx_level_o(tx_level0), .rx_level_o(rx_level0), .rx_ovf_o(ovf0), .ovf_clr_i(ovf_clr),
        .busy_o(busy_o0), .core_start_o(start0), .core_busy_i(cbusy0), .core_mosi_o(mosi0),
        .core_miso_i(miso0), .core_spi_mode_o(mode0), .core_sck_speed_o(speed0),
        .core_word_len_o(wlen0), .core_ifg_o(ifg0), .core_cs_sck_o(cssck0),
        .core_sck_cs_o(sckcs0));

    spi_queue_regs #(.DATA_W(32), .TX_DEPTH(4), .RX_DEPTH(4), .RX_DROP(1'b1)) d1 (
        .GCLK(GCLK), .RST(RST), .enable_i(enable), .cfg_we_i(cfg_we), .spi_mode_i(spi_mode),
        .sck_speed_i(sck_speed), .word_len_i(word_len), .ifg_i(ifg), .cs_sck_i(cs_sck),
        .sck_cs_i(sck_cs), .tx_valid_i(tx_valid), .tx_data_i(tx_data), .tx_ready_o(tx_ready1),
        .rx_valid_o(rx_valid1), .rx_data_o(rx_data1), .rx_ready_i(rx_ready),
        .tx_level_o(tx_level1), .rx_level_o(rx_level1), .rx_ovf_o(ovf1), .ovf_clr_i(ovf_clr),
        .busy_o(busy_o1), .core_start_o(start1), .core_busy_i(cbusy1), .core_mosi_o(mosi1),
        .core_miso_i(miso1), .core_spi_mode_o(mode1), .core_sck_speed_o(speed1),
        .core_word_len_o(wlen1), .core_ifg_o(ifg1), .core_cs_sck_o(cssck1),
        .core_sck_cs_o(sckcs1));

    always #5 GCLK = ~GCLK;

    always @(posedge GCLK) cyc <= cyc + 1;

    // Core stand-in for d0; also logs start-pulse cycles and the cycle busy falls.
    always @(negedge GCLK) begin
        if (RST) begin
            cbusy0 <= 1'b0;
            ccnt0  <= 0;
        end else if (start0) begin
            cbusy0 <= 1'b1;
            ccnt0  <= core_len;
            cword0 <= mosi0;
            starts0.push_back(cyc);
        end else if (cbusy0 && !core_hold) begin
            if (ccnt0 <= 1) begin
                cbusy0    <= 1'b0;
                miso0     <= ~cword0;
                fall_cyc0 <= cyc;
            end else begin
                ccnt0 <= ccnt0 - 1;
            end
        end
    end

    always @(negedge GCLK) begin
        if (RST) begin
            cbusy1 <= 1'b0;
            ccnt1  <= 0;
        end else if (start1) begin
            cbusy1 <= 1'b1;
            ccnt1  <= core_len;
            cword1 <= mosi1;
        end else if (cbusy1 && !core_hold) begin
            if (ccnt1 <= 1) begin
                cbusy1 <= 1'b0;
                miso1  <= ~cword1;
            end else begin
                ccnt1 <= ccnt1 - 1;
            end
        end
    end

    task automatic tick();
        @(posedge GCLK);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_tx(input logic [31:0] w);
        int k;
        tx_data  = w;
        tx_valid = 1'b1;
        k = 0;
        while (!tx_ready0 && k < 500) begin
            tick();
            k++;
        end
        check("tx_accept", tx_ready0, 1'b1);
        tick();
        tx_valid = 1'b0;
    endtask

    task automatic pop_rx(input string name);
        int k;
        logic [31:0] e;
        k = 0;
        while (!rx_valid0 && k < 500) begin
            tick();
            k++;
        end
        check({name, "_valid"}, rx_valid0, 1'b1);
        check({name, "_sb_nonempty"}, exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check({name, "_data"}, rx_data0, e);
        end
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
    endtask

    task automatic wait_idle0(input string name);
        for (int k = 0; k < 500 && (busy_o0 || cbusy0); k++) tick();
        check(name, busy_o0, 1'b0);
    endtask

    task automatic do_reset();
        RST = 1'b1;
        repeat (2) tick();
        RST = 1'b0;
        exp_q.delete();
        tick();
    endtask

    initial begin
        int base, mg;
        vecs[0] = '{32'hA5A5A5A5, 32'h5A5A5A5A};
        vecs[1] = '{32'h12345678, 32'hEDCBA987};
        vecs[2] = '{32'h00000000, 32'hFFFFFFFF};
        vecs[3] = '{32'hFFFFFFFF, 32'h00000000};
        vecs[4] = '{32'h80000001, 32'h7FFFFFFE};
        vecs[5] = '{32'hDEADBEEF, 32'h21524110};

        repeat (3) tick();
        check("rst_tx_ready", tx_ready0, 1'b1);
        check("rst_tx_level", tx_level0, 3'd0);
        check("rst_rx_level", rx_level0, 3'd0);
        check("rst_rx_valid", rx_valid0, 1'b0);
        check("rst_rx_data", rx_data0, 32'd0);
        check("rst_busy", busy_o0, 1'b0);
        check("rst_start", start0, 1'b0);
        check("rst_mosi", mosi0, 32'd0);
        check("rst_cfg", {mode0, speed0, wlen0, ifg0, cssck0, sckcs0}, 30'd0);
        check("rst_ovf1", ovf1, 1'b0);
        RST    = 1'b0;
        enable = 1'b1;
        tick();

        // Config write while idle: visible two edges after the capturing edge.
        cfg_we = 1'b1; spi_mode = 2'b11; sck_speed = 2'b10; word_len = 2'b01;
        ifg = 8'h11; cs_sck = 8'h22; sck_cs = 8'h33;
        tick();
        cfg_we = 1'b0;
        check("cfg_not_yet_1", mode0, 2'd0);
        tick();
        check("cfg_not_yet_2", mode0, 2'd0);
        tick();
        check("cfg_applied", {mode0, speed0, wlen0, ifg0, cssck0, sckcs0},
              {2'b11, 2'b10, 2'b01, 8'h11, 8'h22, 8'h33});

        // Start latency, then a config write during RUN held off until after CAPTURE.
        core_hold = 1'b1;
        push_tx(32'h0F0F0F0F);
        exp_q.push_back(32'hF0F0F0F0);
        check("start_lat_n1", start0, 1'b0);
        tick();
        check("start_lat_n2", start0, 1'b1);
        check("mosi_at_start", mosi0, 32'h0F0F0F0F);
        repeat (2) tick();
        cfg_we = 1'b1; spi_mode = 2'b01; ifg = 8'h44;
        tick();
        cfg_we = 1'b0;
        repeat (3) tick();
        check("cfg_held_run", mode0, 2'b11);
        core_hold = 1'b0;
        for (int k = 0; k < 100 && !rx_valid0; k++) begin
            check("cfg_held_until_capture", mode0, 2'b11);
            tick();
        end
        check("rx_valid_seen", rx_valid0, 1'b1);
        check("rx_latency", cyc - fall_cyc0, 2);
        check("cfg_held_idle", mode0, 2'b11);
        repeat (2) tick();
        check("cfg_applied_after", {mode0, ifg0}, {2'b01, 8'h44});
        pop_rx("t1_pop");
        wait_idle0("t1_idle");

        // Table vectors: more words than the RX FIFO holds, drained in order.
        starts0.delete();
        for (int i = 0; i < 6; i++) begin
            push_tx(vecs[i].tx);
            exp_q.push_back(vecs[i].rx);
        end
        for (int i = 0; i < 6; i++) pop_rx("vec_pop");
        wait_idle0("t2_idle");
        check("t2_starts", starts0.size(), 6);
        mg = 1000;
        for (int i = 1; i < starts0.size(); i++)
            if (starts0[i] - starts0[i-1] < mg) mg = starts0[i] - starts0[i-1];
        check("t2_min_start_gap", mg, 6);

        // Fill TX with launches disabled.
        enable = 1'b0;
        base   = starts0.size();
        for (int i = 0; i < 4; i++) begin
            push_tx(vecs[i].tx);
            exp_q.push_back(vecs[i].rx);
        end
        check("t3_tx_ready_full", tx_ready0, 1'b0);
        check("t3_tx_level", tx_level0, 3'd4);
        check("t3_busy", busy_o0, 1'b1);
        repeat (5) tick();
        check("t3_no_start", starts0.size(), base);
        enable = 1'b1;
        for (int i = 0; i < 4; i++) pop_rx("t3_pop");
        wait_idle0("t3_idle");
        check("t3_starts", starts0.size(), base + 4);

        // RX full with RX_DROP=0 stalls the next launch until a pop.
        for (int i = 2; i < 6; i++) begin
            push_tx(vecs[i].tx);
            exp_q.push_back(vecs[i].rx);
        end
        for (int k = 0; k < 500 && !(rx_level0 == 3'd4 && !busy_o0); k++) tick();
        check("t4_rx_full", rx_level0, 3'd4);
        base = starts0.size();
        push_tx(vecs[0].tx);
        exp_q.push_back(vecs[0].rx);
        repeat (8) tick();
        check("t4_stalled", starts0.size(), base);
        check("t4_tx_level", tx_level0, 3'd1);
        check("t4_ovf0", ovf0, 1'b0);
        pop_rx("t4_pop_first");
        for (int k = 0; k < 100 && starts0.size() == base; k++) tick();
        check("t4_launch_after_pop", starts0.size(), base + 1);
        for (int i = 0; i < 4; i++) pop_rx("t4_pop");
        wait_idle0("t4_idle");

        // RX_DROP=1: overflow drops the word and sets the sticky flag.
        do_reset();
        check("t5_ovf1_reset", ovf1, 1'b0);
        for (int i = 0; i < 4; i++) push_tx(vecs[i].tx);
        for (int k = 0; k < 500 && !(rx_level1 == 3'd4 && !busy_o1); k++) tick();
        check("t5_rx1_full", rx_level1, 3'd4);
        check("t5_rx1_head", rx_data1, vecs[0].rx);
        push_tx(32'h13579BDF);
        for (int k = 0; k < 100 && !ovf1; k++) tick();
        check("t5_ovf_set", ovf1, 1'b1);
        check("t5_rx1_level", rx_level1, 3'd4);
        check("t5_rx1_head_kept", rx_data1, vecs[0].rx);
        check("t5_ovf0_never", ovf0, 1'b0);
        check("t5_d0_stalled", tx_level0, 3'd1);
        tick();
        check("t5_ovf_sticky", ovf1, 1'b1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("t5_ovf_cleared", ovf1, 1'b0);
        ovf_clr = 1'b1;
        push_tx(32'h2468ACE0);
        for (int k = 0; k < 100 && !ovf1; k++) tick();
        check("t5_set_wins_clr", ovf1, 1'b1);
        tick();
        check("t5_clr_after_set", ovf1, 1'b0);
        ovf_clr = 1'b0;
        for (int k = 0; k < 200 && busy_o1; k++) tick();
        check("t5_d1_idle", busy_o1, 1'b0);

        // Reset while a word is in RUN and three more are queued.
        do_reset();
        core_hold = 1'b1;
        for (int i = 0; i < 4; i++) push_tx(vecs[i].tx);
        for (int k = 0; k < 100 && !(cbusy0 && tx_level0 == 3'd3); k++) tick();
        repeat (2) tick();
        check("t6_queued", tx_level0, 3'd3);
        check("t6_in_run", cbusy0, 1'b1);
        RST = 1'b1;
        tick();
        check("t6_tx_level", tx_level0, 3'd0);
        check("t6_rx_level", rx_level0, 3'd0);
        check("t6_start", start0, 1'b0);
        check("t6_busy", busy_o0, 1'b0);
        check("t6_tx_ready", tx_ready0, 1'b1);
        check("t6_rx_valid", rx_valid0, 1'b0);
        RST       = 1'b0;
        core_hold = 1'b0;
        exp_q.delete();
        tick();
        push_tx(vecs[1].tx);
        exp_q.push_back(vecs[1].rx);
        pop_rx("t6_post_reset");
        wait_idle0("t6_idle");
        check("sb_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
